// File: rtl/control_pkg.sv
// Shared constants for the control unit: instruction field encodings,
// condition codes, ALU operation codes and the FSM state type.
package control_pkg;

  // Instruction class, instruction[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Data-processing commands, instruction[24:21]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_MVN = 4'b1111;

  // Condition field, instruction[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // ALU operation codes driven on alu_control
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_NOT_A = 4'b0101;
  localparam logic [3:0] ALU_LSL   = 4'b0110;
  localparam logic [3:0] ALU_LSR   = 4'b0111;

  typedef enum logic {
    ST_EXEC = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Map a data-processing command onto an ALU operation; unknown commands add.
  function automatic logic [3:0] alu_code(input logic [3:0] cmd);
    logic [3:0] code;
    case (cmd)
      CMD_ADD: code = ALU_ADD;
      CMD_SUB: code = ALU_SUB;
      CMD_CMP: code = ALU_SUB;
      CMD_AND: code = ALU_AND;
      CMD_ORR: code = ALU_ORR;
      CMD_EOR: code = ALU_EOR;
      CMD_MOV: code = ALU_ADD;
      CMD_MVN: code = ALU_NOT_A;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluator: decides whether an instruction executes given
// its cond field and the architectural {N,Z,C,V} flags.
import control_pkg::*;

module cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Standard condition table; AL always passes, NV never does.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Processor control unit: instruction decode, condition gating, NZCV flag
// register and a two-state EXEC/WAIT sequencer for data-memory accesses.
// Optional feature macro MEM_TIMEOUT_EN adds a memory-wait timeout that
// aborts the access after TIMEOUT_CYCLES and raises a sticky mem_err.
import control_pkg::*;

module control_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ack,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_reg,
  output logic        alu_src,
  output logic        sh_src,
  output logic        mov_src,
  output logic        mvn_src,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src,
  output logic [3:0]  alu_control,
  output logic        mem_write,
  output logic        mem_req,
  output logic        pc_en,
  output logic [3:0]  flags_q
`ifdef MEM_TIMEOUT_EN
  ,
  output logic        mem_err
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  state_t      state_nxt;
  logic [31:0] instr_q;
  logic [31:0] cur;

  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;
  logic       is_dp, is_mem, is_br;
  logic       rw_dec;
  logic       cond_raw, cond_ex;
  logic       flag_upd, cv_upd;
  logic       mem_req_i, mem_write_i, pc_en_i, rw_i;
  logic       timeout_hit;
  logic       unused_fields;

  // While waiting on memory the access is decoded from the captured word,
  // so the fetch side may change instruction freely.
  assign cur = (state == ST_WAIT) ? instr_q : instruction;

  assign op    = cur[27:26];
  assign i_bit = cur[25];
  assign cmd   = cur[24:21];
  assign s_bit = cur[20];
  assign rd    = cur[15:12];
  assign unused_fields = ^{cur[19:16], cur[11:7], cur[3:0]};

  assign is_dp  = (op == OP_DP);
  assign is_mem = (op == OP_MEM);
  assign is_br  = (op == OP_BR);

  cond_check u_cond (
    .cond    (cur[31:28]),
    .flags   (flags_q),
    .cond_ex (cond_raw)
  );

  // An access already in WAIT has passed its condition check.
  assign cond_ex = (state == ST_WAIT) | cond_raw;

  // Datapath steering decode; independent of execution and sequencing.
  always_comb begin
    imm_src     = op;
    alu_src     = is_dp ? i_bit : (is_mem | is_br);
    reg_src     = {is_mem & ~s_bit, is_br};
    mem_reg     = is_mem & s_bit;
    sh_src      = is_dp & ~i_bit & cur[4];
    mov_src     = is_dp & (cmd == CMD_MOV);
    mvn_src     = is_dp & (cmd == CMD_MVN);
    alu_control = ALU_ADD;
    if (is_dp) begin
      if (sh_src) begin
        alu_control = (cur[6:5] == 2'b01) ? ALU_LSR : ALU_LSL;
      end else begin
        alu_control = alu_code(cmd);
      end
    end
    rw_dec = (is_dp & (cmd != CMD_CMP)) | (is_mem & s_bit);
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Wait counter: held at zero in EXEC, counts each WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ST_EXEC) begin
      wait_cnt <= '0;
    end else if (!timeout_hit) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout error; a coincident ack counts as a normal completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (timeout_hit && !mem_ack) begin
      mem_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Sequencer: memory strobes, PC enable, write enable and next state.
  always_comb begin
    state_nxt   = state;
    mem_req_i   = 1'b0;
    mem_write_i = 1'b0;
    pc_en_i     = 1'b0;
    rw_i        = 1'b0;
    case (state)
      ST_EXEC: begin
        if (cond_ex && is_mem) begin
          mem_req_i   = 1'b1;
          mem_write_i = ~s_bit;
          if (mem_ack) begin
            pc_en_i = 1'b1;
            rw_i    = rw_dec;
          end else begin
            state_nxt = ST_WAIT;
          end
        end else begin
          pc_en_i = 1'b1;
          rw_i    = cond_ex & rw_dec;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          mem_req_i   = 1'b1;
          mem_write_i = ~s_bit;
          pc_en_i     = 1'b1;
          rw_i        = rw_dec;
          state_nxt   = ST_EXEC;
        end else if (timeout_hit) begin
          pc_en_i   = 1'b1;
          state_nxt = ST_EXEC;
        end else begin
          mem_req_i   = 1'b1;
          mem_write_i = ~s_bit;
        end
      end
      default: state_nxt = ST_EXEC;
    endcase
  end

  // Enables are forced low combinationally while reset is asserted.
  assign reg_write = rw_i & ~rst;
  assign mem_req   = mem_req_i & ~rst;
  assign mem_write = mem_write_i & ~rst;
  assign pc_en     = pc_en_i & ~rst;
  assign pc_src    = ~rst & cond_ex & (is_br | (rw_i & (rd == 4'hF)));

  assign flag_upd = (state == ST_EXEC) & cond_ex & is_dp & (s_bit | (cmd == CMD_CMP));
  assign cv_upd   = (cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EXEC;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the instruction word every EXEC cycle so WAIT can replay it.
  always_ff @(posedge clk) begin
    if (state == ST_EXEC) begin
      instr_q <= instruction;
    end
  end

  // Architectural NZCV: N,Z on every flag-setting op, C,V only for add/sub.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (flag_upd) begin
      flags_q[3:2] <= alu_flags[3:2];
      if (cv_upd) begin
        flags_q[1:0] <= alu_flags[1:0];
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a transaction-level model predicts each
// cycle's outputs, a monitor compares them at the falling edge.
module tb_control_unit;

  localparam int TO = 16;
`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  localparam logic [31:0] NOP_INSTR = 32'hEC000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = NOP_INSTR;
  logic [3:0]  alu_flags = 4'h0;
  logic        mem_ack = 1'b0;
  logic        pc_src, reg_write, mem_reg, alu_src, sh_src, mov_src, mvn_src;
  logic [1:0]  imm_src, reg_src;
  logic [3:0]  alu_control;
  logic        mem_write, mem_req, pc_en;
  logic [3:0]  flags_q;
  logic        mem_err;

`ifndef MEM_TIMEOUT_EN
  assign mem_err = 1'b0;
`endif

  control_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .alu_flags(alu_flags),
    .mem_ack(mem_ack), .pc_src(pc_src), .reg_write(reg_write), .mem_reg(mem_reg),
    .alu_src(alu_src), .sh_src(sh_src), .mov_src(mov_src), .mvn_src(mvn_src),
    .imm_src(imm_src), .reg_src(reg_src), .alu_control(alu_control),
    .mem_write(mem_write), .mem_req(mem_req), .pc_en(pc_en), .flags_q(flags_q)
`ifdef MEM_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pc_src, reg_write, mem_reg, alu_src, sh_src, mov_src, mvn_src;
    logic [1:0] imm_src, reg_src;
    logic [3:0] alu_control;
    logic       mem_write, mem_req, pc_en;
    logic [3:0] flags_q;
    logic       mem_err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Architectural model: pending access, NZCV, wait length, error flag.
  bit          m_pend, nxt_pend;
  logic [31:0] m_pinstr, nxt_pinstr;
  logic [3:0]  m_flags, nxt_flags;
  int          m_wcnt, nxt_wcnt;
  bit          m_err, nxt_err;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic bit passes(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] w);
    if (w[27:26] != 2'b00) return 4'd0;
    if (!w[25] && w[4]) return (w[6:5] == 2'b01) ? 4'd7 : 4'd6;
    case (w[24:21])
      4'b0100, 4'b1101: return 4'd0;
      4'b0010, 4'b1010: return 4'd1;
      4'b0000: return 4'd2;
      4'b1100: return 4'd3;
      4'b0001: return 4'd4;
      4'b1111: return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  task automatic predict(input logic [31:0] instr, input logic [3:0] af,
                         input logic ack, output exp_t e);
    logic [31:0] w;
    bit ce, dp, mem, br, ld, is_cmp;
    w      = m_pend ? m_pinstr : instr;
    dp     = (w[27:26] == 2'b00);
    mem    = (w[27:26] == 2'b01);
    br     = (w[27:26] == 2'b10);
    ld     = w[20];
    is_cmp = (w[24:21] == 4'b1010);
    ce     = m_pend ? 1'b1 : passes(w[31:28], m_flags);

    e.imm_src     = w[27:26];
    e.alu_src     = dp ? w[25] : (mem || br);
    e.reg_src     = {mem && !ld, br};
    e.mem_reg     = mem && ld;
    e.sh_src      = dp && !w[25] && w[4];
    e.mov_src     = dp && (w[24:21] == 4'b1101);
    e.mvn_src     = dp && (w[24:21] == 4'b1111);
    e.alu_control = alu_of(w);
    e.flags_q     = m_flags;
    e.mem_err     = m_err;
    e.mem_req     = 0;
    e.mem_write   = 0;
    e.pc_en       = 0;
    e.reg_write   = 0;

    nxt_pend = m_pend; nxt_pinstr = m_pinstr; nxt_flags = m_flags;
    nxt_wcnt = m_wcnt; nxt_err = m_err;

    if (!m_pend) begin
      if (ce && mem) begin
        e.mem_req = 1; e.mem_write = !ld;
        if (ack) begin
          e.pc_en = 1; e.reg_write = ld;
        end else begin
          nxt_pend = 1; nxt_pinstr = instr; nxt_wcnt = 0;
        end
      end else begin
        e.pc_en = 1;
        e.reg_write = ce && dp && !is_cmp;
        if (ce && dp && (w[20] || is_cmp)) begin
          nxt_flags[3:2] = af[3:2];
          if (w[24:21] == 4'b0100 || w[24:21] == 4'b0010 || is_cmp)
            nxt_flags[1:0] = af[1:0];
        end
      end
    end else if (ack) begin
      e.mem_req = 1; e.mem_write = !ld; e.pc_en = 1; e.reg_write = ld;
      nxt_pend = 0;
    end else if (TIMEOUT_ON && m_wcnt == TO) begin
      e.pc_en = 1; nxt_pend = 0; nxt_err = 1;
    end else begin
      e.mem_req = 1; e.mem_write = !ld; nxt_wcnt = m_wcnt + 1;
    end
    e.pc_src = ce && (br || (e.reg_write && w[15:12] == 4'hF));
  endtask

  task automatic cycle(input logic [31:0] instr, input logic [3:0] af, input logic ack);
    exp_t e;
    @(posedge clk);
    #1;
    m_pend = nxt_pend; m_pinstr = nxt_pinstr; m_flags = nxt_flags;
    m_wcnt = nxt_wcnt; m_err = nxt_err;
    instruction = instr; alu_flags = af; mem_ack = ack;
    predict(instr, af, ack, e);
    exp_q.push_back(e);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk({tag, "_reg_write"}, {3'b0, reg_write}, 4'h0);
    chk({tag, "_mem_write"}, {3'b0, mem_write}, 4'h0);
    chk({tag, "_mem_req"},   {3'b0, mem_req},   4'h0);
    chk({tag, "_pc_src"},    {3'b0, pc_src},    4'h0);
    chk({tag, "_pc_en"},     {3'b0, pc_en},     4'h0);
    chk({tag, "_flags_q"},   flags_q,           4'h0);
`ifdef MEM_TIMEOUT_EN
    chk({tag, "_mem_err"},   {3'b0, mem_err},   4'h0);
`endif
    m_pend = 0; m_pinstr = '0; m_flags = 4'h0; m_wcnt = 0; m_err = 0;
    nxt_pend = 0; nxt_pinstr = '0; nxt_flags = 4'h0; nxt_wcnt = 0; nxt_err = 0;
    @(posedge clk);
    #1;
    instruction = NOP_INSTR; mem_ack = 1'b0; alu_flags = 4'h0;
    #1;
    chk({tag, "_hold_pc_en"},     {3'b0, pc_en},     4'h0);
    chk({tag, "_hold_reg_write"}, {3'b0, reg_write}, 4'h0);
    chk({tag, "_hold_flags_q"},   flags_q,           4'h0);
    rst = 1'b0;
  endtask

  // Monitor: compare one predicted cycle per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_src",      {3'b0, pc_src},      {3'b0, e.pc_src});
        chk("reg_write",   {3'b0, reg_write},   {3'b0, e.reg_write});
        chk("mem_reg",     {3'b0, mem_reg},     {3'b0, e.mem_reg});
        chk("alu_src",     {3'b0, alu_src},     {3'b0, e.alu_src});
        chk("sh_src",      {3'b0, sh_src},      {3'b0, e.sh_src});
        chk("mov_src",     {3'b0, mov_src},     {3'b0, e.mov_src});
        chk("mvn_src",     {3'b0, mvn_src},     {3'b0, e.mvn_src});
        chk("imm_src",     {2'b0, imm_src},     {2'b0, e.imm_src});
        chk("reg_src",     {2'b0, reg_src},     {2'b0, e.reg_src});
        chk("alu_control", alu_control,         e.alu_control);
        chk("mem_write",   {3'b0, mem_write},   {3'b0, e.mem_write});
        chk("mem_req",     {3'b0, mem_req},     {3'b0, e.mem_req});
        chk("pc_en",       {3'b0, pc_en},       {3'b0, e.pc_en});
        chk("flags_q",     flags_q,             e.flags_q);
        chk("mem_err",     {3'b0, mem_err},     {3'b0, e.mem_err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0] cmds [8];
    cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b1111};

    reset_check("reset");

    // ADD immediate, CMP setting Z, conditional branch taken / not taken
    cycle(32'hE2821005, 4'h0, 1'b0);
    cycle(32'hE3500000, 4'h4, 1'b0);
    cycle(32'h0A000002, 4'h0, 1'b0);
    cycle(32'hE3500000, 4'h0, 1'b0);
    cycle(32'h0A000002, 4'h0, 1'b0);

    // Load with ack three cycles late; fetch side changes meanwhile
    cycle(32'hE5943008, 4'h0, 1'b0);
    cycle($urandom, 4'($urandom), 1'b0);
    cycle($urandom, 4'($urandom), 1'b0);
    cycle($urandom, 4'($urandom), 1'b1);

    // Single-cycle store, then an ack with no request outstanding
    cycle(32'hE5843008, 4'h0, 1'b1);
    cycle(NOP_INSTR, 4'h0, 1'b1);

    // Long unacknowledged load (aborts when the timeout is built in)
    for (int i = 0; i < TO + 4; i++) cycle(32'hE5943008, 4'h0, 1'b0);
    cycle(32'hE5943008, 4'h0, 1'b1);
    cycle(NOP_INSTR, 4'h0, 1'b0);

    // Flags nonzero, then reset while an access is pending
    cycle(32'hE3500000, 4'hF, 1'b0);
    cycle(32'hE5943008, 4'h0, 1'b0);
    cycle(32'hE5943008, 4'h0, 1'b0);
    reset_check("reset_in_wait");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      if ($urandom_range(3) != 0) r[31:28] = 4'hE;
      if ($urandom_range(1) != 0) r[24:21] = cmds[$urandom_range(7)];
      if ($urandom_range(7) == 0) r[15:12] = 4'hF;
      cycle(r, 4'($urandom), ($urandom_range(2) == 0));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 4'(exp_q.size()), 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the number of memory-wait cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 instruction  input  32  current instruction word.
REQ-005 alu_flags  input  4  {N,Z,C,V} from the ALU for the current instruction.
REQ-006 mem_ack  input  1  data memory completion strobe.
REQ-007 The control outputs SHALL be pc_src, reg_write, mem_reg, alu_src, sh_src, mov_src, mvn_src (1 bit each), imm_src and reg_src (2 bits each), and alu_control (4 bits), all driving the datapath.
REQ-008 mem_write, mem_req, pc_en  output  1 each  data memory strobes and PC update enable.
REQ-009 flags_q  output  4  architectural NZCV register.
REQ-010 mem_err  output  1  sticky timeout error; present only with MEM_TIMEOUT_EN.

Function
REQ-011 Decode SHALL use op=instruction[27:26] (00 DP, 01 MEM, 10 BR, 11 NOP), I=[25], cmd=[24:21], S=[20] (L for MEM), Rd=[15:12], cond=[31:28].
REQ-012 cond_ex SHALL evaluate flags_q per EQ..LE (0000-1101); 1110 SHALL always pass and 1111 SHALL never pass.
REQ-013 If cond_ex=0, reg_write, mem_write, mem_req, pc_src and the flag update SHALL be 0.
REQ-014 The decode SHALL set imm_src=op, alu_src to I for DP and to 1 for MEM/BR, reg_src[0]=BR, reg_src[1]=MEM store, and mem_reg=MEM load.
REQ-015 alu_control SHALL map cmd as ADD 0100->ADD, SUB 0010/CMP 1010->SUB, AND 0000->AND, ORR 1100->ORR, EOR 0001->EOR, MOV 1101->ADD with mov_src=1, and MVN 1111->NOT_A with mvn_src=1; MEM and BR SHALL use ADD.
REQ-016 sh_src SHALL be 1 for DP with I=0 and instruction[4]=1, and alu_control SHALL then be LSL for [6:5]=00 and LSR for [6:5]=01.
REQ-017 reg_write SHALL be asserted for DP except CMP and for MEM load, and pc_src SHALL be asserted for BR, or when reg_write=1 and Rd=15.
REQ-018 flags_q SHALL load at the edge when cond_ex=1 and the instruction is DP with (S=1 or CMP): N,Z always; C,V only for ADD/SUB/CMP; other bits hold.
REQ-019 The FSM SHALL have two states, EXEC and WAIT.
REQ-020 In EXEC, non-MEM or non-executing instructions SHALL set pc_en=1 and remain in EXEC.
REQ-021 In EXEC, an executing MEM instruction SHALL assert mem_req, and mem_write for stores; with mem_ack=1 in the same cycle it SHALL complete with pc_en=1, otherwise it SHALL move to WAIT with pc_en=0 and reg_write=0.
REQ-022 In WAIT, mem_req, mem_write and the decoded controls SHALL be held, with pc_en=0 and reg_write=0; on mem_ack=1 the unit SHALL assert reg_write (loads) and pc_en=1, and return to EXEC.
REQ-023 mem_ack arriving while mem_req=0 SHALL be ignored.

Reset
REQ-024 rst SHALL immediately force state=EXEC, flags_q=0, wait counter=0 and mem_err=0.
REQ-025 While rst=1, reg_write, mem_write, mem_req, pc_src and pc_en SHALL be 0.
REQ-026 rst asserted in WAIT SHALL abandon the access with no register write.

Configuration
REQ-027 With MEM_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT and increment per WAIT cycle; when it reaches TIMEOUT_CYCLES without mem_ack, the unit SHALL drop mem_req, set pc_en=1 with reg_write=0 for one cycle, set mem_err (sticky until reset) and return to EXEC.
REQ-028 mem_ack coinciding with the timeout cycle SHALL take priority as a normal completion.
REQ-029 Without MEM_TIMEOUT_EN, the counter and mem_err SHALL be absent and WAIT SHALL persist until mem_ack.

Structure
REQ-030 The package control_pkg SHALL hold the op, cmd, cond and ALU-code constants (ADD 0000, SUB 0001, AND 0010, ORR 0011, EOR 0100, NOT_A 0101, LSL 0110, LSR 0111) and the state enum.
REQ-031 Condition evaluation SHALL be a sub-module named cond_check (cond, flags -> cond_ex).

Verification
REQ-032 Scenario ADD: E2821005 -> reg_write=1, alu_src=1, imm_src=00, alu_control=ADD, pc_en=1, flags_q unchanged.
REQ-033 Scenario CMP/branch: E3500000 with alu_flags=0100 -> flags_q=0100, reg_write=0; then 0A000002 -> pc_src=1, and with flags_q=0000 -> pc_src=0.
REQ-034 Scenario load wait: E5943008 with mem_ack delayed 3 cycles -> pc_en=0 and reg_write=0 for 3 cycles, then reg_write=1, mem_reg=1, pc_en=1 on the ack cycle.
REQ-035 Scenario store: E5843008 with mem_ack=1 in EXEC -> mem_write=1, mem_req=1, reg_src=10, reg_write=0, single cycle.
REQ-036 Scenario timeout: with MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> abort with pc_en=1 and mem_err=1 held; rst clears mem_err.
REQ-037 Scenario reset in WAIT: rst asserted in WAIT -> state EXEC, all enables 0 asynchronously, flags_q=0.
